div_controller: RTL and testbench

//  Multi-cycle controller for the MIPS DIV/DIVU instructions, alongside the EX stage.

---
 rtl/div_controller.sv | 163 ++++++++++++++++
 tb/tb_div_controller.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_controller.sv
// Multi-cycle DIV/DIVU controller beside EX: radix-2 restoring divider,
// one quotient bit per cycle, with stall, sign fix-up and divide-by-zero.
//
// Ports:
//   clk, rst (async, active-low)
//   start, signed_div, dividend, divisor, annul   - request from EX
//   stall_req                                     - hold IF/ID/EX
//   done, quotient (LO), remainder (HI)           - result, one-cycle pulse
module div_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  annul,
    output logic                  stall_req,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_ZERO,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [W-1:0]         r_dvd;
    logic [W-1:0]         r_dvs;
    logic [W-1:0]         r_rem;
    logic [W-1:0]         r_quo;
    logic [W-1:0]         r_quotient;
    logic [W-1:0]         r_remainder;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_neg_q;
    logic                 r_neg_r;

    logic [W:0]           w_shift;
    logic [W:0]           w_trial;
    logic                 w_borrow;
    logic [W-1:0]         w_rem_nxt;
    logic [W-1:0]         w_quo_nxt;
    logic                 w_last;
    logic                 w_req;

    // Keep the bit shifted out of the partial remainder so divisors
    // above 2**(W-1) still compare correctly.
    assign w_shift   = {r_rem, r_dvd[W-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_borrow  = w_trial[W];
    assign w_rem_nxt = w_borrow ? w_shift[W-1:0] : w_trial[W-1:0];
    assign w_quo_nxt = {r_quo[W-2:0], ~w_borrow};
    assign w_last    = (r_cnt == CNT_WIDTH'(W - 1));
    assign w_req     = start & ~annul;

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        stall_req = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Gated by rst so the pipeline is released during reset.
                stall_req = w_req & rst;
                if (w_req) begin
                    w_next = (divisor == '0) ? S_DIV_ZERO : S_BUSY;
                end
            end
            S_DIV_ZERO: begin
                stall_req = 1'b1;
                w_next    = annul ? S_IDLE : S_DONE;
            end
            S_BUSY: begin
                stall_req = 1'b1;
                if (annul) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_dvd <= (signed_div && dividend[W-1])
                                 ? -dividend : dividend;
                        r_dvs <= (signed_div && divisor[W-1])
                                 ? -divisor : divisor;
                        r_neg_q <= signed_div
                                   & (dividend[W-1] ^ divisor[W-1]);
                        r_neg_r <= signed_div & dividend[W-1];
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_DIV_ZERO: begin
                    if (!annul) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                    end
                end
                S_BUSY: begin
                    if (!annul) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_dvd <= r_dvd << 1;
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                        // Results land as DONE is entered so they are
                        // valid in the same cycle as the done pulse.
                        if (w_last) begin
                            r_quotient  <= r_neg_q ? -w_quo_nxt : w_quo_nxt;
                            r_remainder <= r_neg_r ? -w_rem_nxt : w_rem_nxt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench for div_controller: directed corner cases plus
// randomized divides checked against a plain-arithmetic reference model.
module tb_div_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stall_req;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int total;
    int bad;

    div_controller #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .dividend  (dividend),
        .divisor   (divisor),
        .annul     (annul),
        .stall_req (stall_req),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(
        input  logic        sd,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] q,
        output logic [31:0] r
    );
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issues one request, holds start until done is seen, then drops it.
    // Reports latency, result, stall_req errors and any activity after.
    task automatic drive_div(
        input  logic        sd,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  bit          scramble,
        output int          lat,
        output logic [31:0] q,
        output logic [31:0] r,
        output int          stall_err,
        output bit          extra
    );
        lat       = -1;
        stall_err = 0;
        extra     = 1'b0;
        q         = 'x;
        r         = 'x;
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        #1;
        if (stall_req !== 1'b1) stall_err++;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                q   = quotient;
                r   = remainder;
                if (stall_req !== 1'b0) stall_err++;
            end else if (stall_req !== 1'b1) begin
                stall_err++;
            end
            if (scramble) begin
                dividend   = $urandom;
                divisor    = $urandom;
                signed_div = 1'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        if (done !== 1'b0 || stall_req !== 1'b0) extra = 1'b1;
        @(negedge clk);
        if (done !== 1'b0 || stall_req !== 1'b0) extra = 1'b1;
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        annul      = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (stall_req !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl stall=%b done=%b want 0 0",
                     stall_req, done);
        end
        total++;
        if (quotient !== 32'd0 || remainder !== 32'd0) begin
            bad++;
            $display("FAIL reset_data q=%h r=%h want 0 0",
                     quotient, remainder);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release stall=%b done=%b want 0 0",
                     stall_req, done);
        end
    endtask

    task automatic test_divu_basic;
        int          lat;
        int          se;
        bit          ex;
        logic [31:0] q;
        logic [31:0] r;
        drive_div(1'b0, 32'd100, 32'd7, 1'b0, lat, q, r, se, ex);
        total++;
        if (lat != 33) begin
            bad++;
            $display("FAIL divu_lat got=%0d want=33", lat);
        end
        total++;
        if (q !== 32'd14 || r !== 32'd2) begin
            bad++;
            $display("FAIL divu_100_7 q=%0d r=%0d want 14 2", q, r);
        end
        total++;
        if (se != 0) begin
            bad++;
            $display("FAIL divu_stall errors=%0d want 0", se);
        end
        total++;
        if (ex) begin
            bad++;
            $display("FAIL divu_restart activity after done=1 want 0");
        end
        repeat (5) @(negedge clk);
        total++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            bad++;
            $display("FAIL divu_hold q=%0d r=%0d want 14 2",
                     quotient, remainder);
        end
    endtask

    task automatic test_signed;
        logic [31:0] av [3];
        logic [31:0] bv [3];
        logic [31:0] qv [3];
        logic [31:0] rv [3];
        int          lat;
        int          se;
        bit          ex;
        logic [31:0] q;
        logic [31:0] r;
        av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2;
        qv[0] = 32'hFFFF_FFFD; rv[0] = 32'hFFFF_FFFF;
        av[1] = 32'd7;         bv[1] = 32'hFFFF_FFFE;
        qv[1] = 32'hFFFF_FFFD; rv[1] = 32'd1;
        av[2] = 32'h8000_0000; bv[2] = 32'hFFFF_FFFF;
        qv[2] = 32'h8000_0000; rv[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            drive_div(1'b1, av[i], bv[i], 1'b0, lat, q, r, se, ex);
            total++;
            if (lat != 33 || q !== qv[i] || r !== rv[i]) begin
                bad++;
                $display("FAIL signed_%0d lat=%0d q=%h r=%h want 33 %h %h",
                         i, lat, q, r, qv[i], rv[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int          lat;
        int          se;
        bit          ex;
        logic [31:0] q;
        logic [31:0] r;
        drive_div(1'b0, 32'd100, 32'd7, 1'b0, lat, q, r, se, ex);
        drive_div(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, lat, q, r, se, ex);
        total++;
        if (lat != 2 || q !== 32'd0 || r !== 32'd0) begin
            bad++;
            $display("FAIL divzero lat=%0d q=%h r=%h want 2 0 0",
                     lat, q, r);
        end
        total++;
        if (se != 0 || ex) begin
            bad++;
            $display("FAIL divzero_stall errors=%0d extra=%0b want 0 0",
                     se, ex);
        end
        repeat (4) @(negedge clk);
        total++;
        if (quotient !== 32'd0 || remainder !== 32'd0) begin
            bad++;
            $display("FAIL divzero_hold q=%h r=%h want 0 0",
                     quotient, remainder);
        end
    endtask

    task automatic test_annul;
        int          lat;
        int          se;
        bit          ex;
        bit          seen;
        logic [31:0] q;
        logic [31:0] r;
        drive_div(1'b0, 32'd100, 32'd7, 1'b0, lat, q, r, se, ex);
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        #1;
        total++;
        if (stall_req !== 1'b0) begin
            bad++;
            $display("FAIL annul_stall got=%b want 0", stall_req);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || stall_req !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL annul_nodone activity=1 want 0");
        end
        total++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            bad++;
            $display("FAIL annul_keep q=%0d r=%0d want 14 2",
                     quotient, remainder);
        end
        drive_div(1'b0, 32'd1000, 32'd3, 1'b0, lat, q, r, se, ex);
        total++;
        if (lat != 33 || q !== 32'd333 || r !== 32'd1) begin
            bad++;
            $display("FAIL annul_next lat=%0d q=%0d r=%0d want 33 333 1",
                     lat, q, r);
        end
    endtask

    task automatic test_annul_start_idle;
        bit seen;
        @(negedge clk);
        start    = 1'b1;
        annul    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        #1;
        total++;
        if (stall_req !== 1'b0) begin
            bad++;
            $display("FAIL annul_idle_stall got=%b want 0", stall_req);
        end
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        seen  = 1'b0;
        repeat (36) begin
            @(negedge clk);
            if (done !== 1'b0 || stall_req !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL annul_idle_start activity=1 want 0");
        end
    endtask

    task automatic test_random;
        int          lat;
        int          se;
        bit          ex;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] a;
        logic [31:0] b;
        logic        sd;
        int          sel;
        for (int i = 0; i < 24; i++) begin
            sd  = 1'($urandom);
            a   = $urandom;
            sel = int'($urandom_range(0, 5));
            if (sel == 0)      b = 32'd0;
            else if (sel <= 2) b = $urandom_range(1, 15);
            else if (sel == 3) b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else               b = $urandom;
            if (sel == 0 && i[0]) a = 32'h8000_0000;
            model(sd, a, b, eq, er);
            drive_div(sd, a, b, 1'b1, lat, q, r, se, ex);
            total++;
            if (lat != ((b == 32'd0) ? 2 : 33) || q !== eq || r !== er
                || se != 0 || ex) begin
                bad++;
                $display("FAIL rand_%0d sd=%0b %h/%h lat=%0d q=%h r=%h want %h %h se=%0d ex=%0b",
                         i, sd, a, b, lat, q, r, eq, er, se, ex);
            end
        end
    endtask

    task automatic test_reset_mid_busy;
        int          lat;
        int          se;
        bit          ex;
        logic [31:0] q;
        logic [31:0] r;
        drive_div(1'b0, 32'd100, 32'd7, 1'b0, lat, q, r, se, ex);
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (stall_req !== 1'b0 || done !== 1'b0
            || quotient !== 32'd0 || remainder !== 32'd0) begin
            bad++;
            $display("FAIL rst_busy stall=%b done=%b q=%h r=%h want 0 0 0 0",
                     stall_req, done, quotient, remainder);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive_div(1'b0, 32'd100, 32'd7, 1'b0, lat, q, r, se, ex);
        total++;
        if (lat != 33 || q !== 32'd14 || r !== 32'd2 || se != 0) begin
            bad++;
            $display("FAIL rst_after lat=%0d q=%0d r=%0d se=%0d want 33 14 2 0",
                     lat, q, r, se);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_divu_basic;
        test_signed;
        test_div_zero;
        test_annul;
        test_annul_start_idle;
        test_random;
        test_reset_mid_busy;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
